// File: rtl/req_arbiter4_if.sv
// Request/grant bundle between requesting units and req_arbiter4.
// The master side drives requests and release; the slave side (the arbiter) drives the grant.
interface req_arbiter4_if;
    logic [3:0] D;
    logic       done;
    logic [3:0] grant;
    logic       x;
    logic       y;
    logic       V;
    logic       timeout;

    modport master (
        output D,
        output done,
        input  grant,
        input  x,
        input  y,
        input  V,
        input  timeout
    );

    modport slave (
        input  D,
        input  done,
        output grant,
        output x,
        output y,
        output V,
        output timeout
    );
endinterface

// File: rtl/req_arbiter4.sv
// Four-requester arbiter with grant holding, release handshake and hold-time limit.
// Optional round-robin search order is enabled by defining ARB_ROUND_ROBIN_EN.
module req_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic          clk,
    input  logic          reset_b,
    req_arbiter4_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // CNT_W must be wide enough that MAX_HOLD-1 is representable.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_n;
    logic [1:0]       owner_q, owner_n;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_n;
    logic             timeout_q, timeout_n;

    logic [1:0]       winner;
    logic             owner_req;
    logic             limit_hit;
    logic             release_req;

    logic [3:0]       grant_c;
    logic [1:0]       idx_c;
    logic             valid_c;

    // Search downward starting just below 'last', wrapping, with 'last' itself checked last.
    function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last - 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last_owner_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            last_owner_q <= 2'd0;
        end else if (state_q == BUSY && release_req) begin
            last_owner_q <= owner_q;
        end
    end

    assign winner = pick_winner(bus.D, last_owner_q);
`else
    // Starting the search below index 0 yields the fixed order 3,2,1,0.
    assign winner = pick_winner(bus.D, 2'd0);
`endif

    assign owner_req   = bus.D[owner_q];
    assign limit_hit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign release_req = bus.done || !owner_req || limit_hit;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            owner_q    <= 2'd0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            owner_q    <= owner_n;
            hold_cnt_q <= hold_cnt_n;
            timeout_q  <= timeout_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        owner_n    = owner_q;
        hold_cnt_n = hold_cnt_q;
        timeout_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.D) begin
                    state_n    = BUSY;
                    owner_n    = winner;
                    hold_cnt_n = '0;
                end
            end
            BUSY: begin
                if (release_req) begin
                    state_n   = IDLE;
                    owner_n   = 2'd0;
                    // Flag only a release forced purely by the hold limit.
                    timeout_n = limit_hit && !bus.done && owner_req;
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_n = hold_cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_comb begin
        grant_c = 4'b0000;
        idx_c   = 2'b00;
        valid_c = 1'b0;
        if (state_q == BUSY) begin
            grant_c[owner_q] = 1'b1;
            idx_c            = owner_q;
            valid_c          = 1'b1;
        end
    end

    assign bus.grant   = grant_c;
    assign bus.x       = idx_c[1];
    assign bus.y       = idx_c[0];
    assign bus.V       = valid_c;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_req_arbiter4.sv
// Bench for req_arbiter4: directed scenarios followed by random requests,
// all compared against a cycle-level behavioural model of the arbiter.
module tb_req_arbiter4;

    localparam int MH = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic reset_b;
    int   checks = 0;
    int   errors = 0;

    // Model: owner index or -1 when idle, cycles the grant has been visible.
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_last  = 0;
    logic m_timeout = 1'b0;

    req_arbiter4_if bus();

    req_arbiter4 #(.MAX_HOLD(MH), .CNT_W(5)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] req, input int last);
        int base;
        base = RR ? last : 0;
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (base - k + 8) % 4;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_held    = 0;
        m_last    = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_edge();
        logic own;
        logic lim;
        if (!reset_b) begin
            model_reset();
            return;
        end
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            if (bus.D != 4'b0000) begin
                m_owner = pick(bus.D, m_last);
                m_held  = 1;
            end
        end else begin
            own = bus.D[m_owner];
            lim = (MH != 0) && (m_held == MH);
            if (bus.done || !own || lim) begin
                m_timeout = !bus.done && own;
                m_last    = m_owner;
                m_owner   = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] obs;
        logic [7:0] exp;
        logic [3:0] g;
        logic [1:0] o;
        g   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        o   = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
        exp = {g, o, (m_owner >= 0), m_timeout};
        obs = {bus.grant, bus.x, bus.y, bus.V, bus.timeout};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s grant/x/y/V/timeout obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_bits(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    logic [3:0] rr_seq [5];
    logic [3:0] d_prev;

    initial begin
        reset_b  = 1'b0;
        bus.D    = 4'b0000;
        bus.done = 1'b0;
        model_reset();
        #1;
        check_model("reset_init");
        expect_bits("reset_xy", {2'b00, bus.x, bus.y}, 4'b0000);
        tick("reset_hold0");
        tick("reset_hold1");
        reset_b = 1'b1;
        tick("idle_empty");
        expect_bits("idle_empty_V", {3'b000, bus.V}, 4'b0000);

        // Priority: D3 beats D1.
        bus.D = 4'b1010;
        tick("prio_grant");
        expect_bits("prio_grant", bus.grant, 4'b1000);
        expect_bits("prio_xy", {2'b00, bus.x, bus.y}, 4'b0011);
        bus.done = 1'b1;
        bus.D    = 4'b0010;
        tick("prio_release");
        expect_bits("prio_gap_V", {3'b000, bus.V}, 4'b0000);
        bus.done = 1'b0;
        tick("prio_second");
        expect_bits("prio_second", bus.grant, 4'b0010);
        expect_bits("prio_second_xy", {2'b00, bus.x, bus.y}, 4'b0001);
        bus.D = 4'b0000;
        tick("prio_drop");
        tick("prio_idle");

        // No preemption by a higher-priority request.
        bus.D = 4'b0001;
        tick("nopre_grant");
        expect_bits("nopre_grant", bus.grant, 4'b0001);
        bus.D = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            tick("nopre_hold");
            expect_bits("nopre_hold", bus.grant, 4'b0001);
        end
        bus.done = 1'b1;
        tick("nopre_release");
        expect_bits("nopre_gap", bus.grant, 4'b0000);
        bus.done = 1'b0;
        tick("nopre_next");
        expect_bits("nopre_next", bus.grant, 4'b1000);
        bus.D = 4'b0000;
        tick("nopre_drop");
        tick("nopre_idle");

        // Hold limit: forced release after MH cycles.
        bus.D = 4'b0100;
        tick("hold_grant");
        for (int i = 0; i < MH - 1; i++) begin
            tick("hold_busy");
            expect_bits("hold_busy", bus.grant, 4'b0100);
        end
        tick("hold_expire");
        expect_bits("hold_timeout", {2'b00, bus.V, bus.timeout}, 4'b0001);
        tick("hold_regrant");
        expect_bits("hold_regrant", {bus.grant}, 4'b0100);
        expect_bits("hold_regrant_to", {3'b000, bus.timeout}, 4'b0000);
        for (int i = 0; i < MH - 1; i++) tick("hold_busy2");
        bus.done = 1'b1;
        tick("hold_done_limit");
        expect_bits("hold_done_limit", {2'b00, bus.V, bus.timeout}, 4'b0000);
        bus.done = 1'b0;

        // Requester drop.
        bus.D = 4'b0010;
        tick("drop_grant");
        expect_bits("drop_grant", bus.grant, 4'b0010);
        bus.D = 4'b0000;
        tick("drop_release");
        expect_bits("drop_release", {2'b00, bus.V, bus.timeout}, 4'b0000);

        // Asynchronous reset while busy.
        bus.D = 4'b0100;
        tick("arst_grant");
        expect_bits("arst_grant", bus.grant, 4'b0100);
        #2;
        reset_b = 1'b0;
        #1;
        model_reset();
        expect_bits("arst_grant_now", bus.grant, 4'b0000);
        expect_bits("arst_V_now", {3'b000, bus.V}, 4'b0000);
        tick("arst_held");
        reset_b = 1'b1;
        bus.D   = 4'b0001;
        tick("arst_after");
        expect_bits("arst_after", bus.grant, 4'b0001);
        expect_bits("arst_after_xy", {2'b00, bus.x, bus.y}, 4'b0000);
        bus.D    = 4'b0000;
        bus.done = 1'b1;
        tick("arst_release");
        bus.done = 1'b0;
        tick("arst_idle");

        // All requesting, done pulsed on each grant.
        if (RR) rr_seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        else    rr_seq = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        bus.D = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick("rr_grant");
            expect_bits("rr_seq", bus.grant, rr_seq[i]);
            bus.done = 1'b1;
            tick("rr_gap");
            bus.done = 1'b0;
        end
        bus.D = 4'b0000;
        tick("rr_idle");

        // Random requests against the model.
        d_prev = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) d_prev = 4'($urandom_range(0, 15));
            bus.D    = d_prev;
            bus.done = ($urandom_range(0, 5) == 0);
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
